// File: rtl/move_validator.sv
// move_validator: Othello move legality check over a 10x10 walled board memory.
// Define MOVE_VD_DIR_MASK_EN for a full eight-direction scan with a per-direction dir_mask output.
module move_validator #(
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] s_addr_in,
    input  logic              player,
    output logic [ADDR_W-1:0] addr_to_mem,
    input  logic [1:0]        data_from_mem,
    output logic              busy,
    output logic              done,
    output logic              mv_valid,
    input  logic              ack_in
`ifdef MOVE_VD_DIR_MASK_EN
    ,
    output logic [7:0]        dir_mask
`endif
);
    typedef enum logic [2:0] {IDLE, CELL_RD, CELL_EV, DIR_RD, DIR_EV, RESULT, ACK_WAIT} state_t;
    localparam int OFF [8] = '{-11, -10, -9, -1, 1, 9, 10, 11};

    state_t            r_state;
    logic [ADDR_W-1:0] r_move;
    logic [ADDR_W-1:0] r_cur;
    logic [1:0]        r_own;
    logic [2:0]        r_dir;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_next_cur;
    logic              w_opp;
    logic              w_legal;
    logic              w_fin;
    logic              w_ok;

    // Offsets wrap modulo 2^ADDR_W; the wall ring keeps every probe on the board.
    assign w_off      = ADDR_W'(OFF[r_dir]);
    assign w_next_cur = r_move + ADDR_W'(OFF[r_dir + 3'd1]);
    assign w_opp      = data_from_mem == ~r_own;
    assign w_legal    = data_from_mem == r_own && r_cnt != 3'd0;

`ifdef MOVE_VD_DIR_MASK_EN
    logic [7:0] r_mask;
    logic [7:0] w_hit;
    assign w_hit    = {7'd0, w_legal} << r_dir;
    assign dir_mask = r_mask;
    assign w_fin    = r_dir == 3'd7;
    assign w_ok     = |(r_mask | w_hit);
`else
    assign w_fin    = w_legal || r_dir == 3'd7;
    assign w_ok     = w_legal;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_move      <= '0;
            r_cur       <= '0;
            r_own       <= '0;
            r_dir       <= '0;
            r_cnt       <= '0;
            addr_to_mem <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mv_valid    <= 1'b0;
`ifdef MOVE_VD_DIR_MASK_EN
            r_mask      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_move      <= s_addr_in;
                    r_own       <= player ? 2'b10 : 2'b01;
                    addr_to_mem <= s_addr_in;
                    busy        <= 1'b1;
`ifdef MOVE_VD_DIR_MASK_EN
                    r_mask      <= '0;
`endif
                    r_state     <= CELL_RD;
                end
                CELL_RD: r_state <= CELL_EV;
                CELL_EV: if (data_from_mem != 2'b00) begin
                    done     <= 1'b1;
                    mv_valid <= 1'b0;
                    r_state  <= RESULT;
                end else begin
                    r_dir       <= '0;
                    r_cnt       <= '0;
                    r_cur       <= r_move + ADDR_W'(OFF[0]);
                    addr_to_mem <= r_move + ADDR_W'(OFF[0]);
                    r_state     <= DIR_RD;
                end
                DIR_RD: r_state <= DIR_EV;
                DIR_EV: if (w_opp) begin
                    r_cnt       <= r_cnt + 3'd1;
                    r_cur       <= r_cur + w_off;
                    addr_to_mem <= r_cur + w_off;
                    r_state     <= DIR_RD;
                end else begin
`ifdef MOVE_VD_DIR_MASK_EN
                    r_mask <= r_mask | w_hit;
`endif
                    if (w_fin) begin
                        done     <= 1'b1;
                        mv_valid <= w_ok;
                        r_state  <= RESULT;
                    end else begin
                        r_dir       <= r_dir + 3'd1;
                        r_cnt       <= '0;
                        r_cur       <= w_next_cur;
                        addr_to_mem <= w_next_cur;
                        r_state     <= DIR_RD;
                    end
                end
                RESULT: begin
                    done    <= 1'b0;
                    busy    <= mv_valid;
                    r_state <= mv_valid ? ACK_WAIT : IDLE;
                end
                ACK_WAIT: if (ack_in) begin
                    mv_valid <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
